// File: rtl/btn_pkg.sv
// Shared types and constants for the five-button debouncer.
package btn_pkg;

  localparam int NUM_BTNS = 5;

  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_D = 2;
  localparam int BTN_L = 3;
  localparam int BTN_R = 4;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    HELD         = 2'd2,
    RELEASE_PEND = 2'd3
  } btn_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM and auto-repeat timer.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = 1_000_000,
  parameter int REPEAT_DELAY_CYCLES = 50_000_000,
  parameter int REPEAT_RATE_CYCLES  = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES)) + 1;
  localparam logic [CW-1:0] STAB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX    = '1;

  logic          sync1_reg, sync2_reg;
  btn_state_e    state_reg, state_next;
  logic [CW-1:0] stab_reg, stab_next;
  logic [CW-1:0] rep_reg, rep_next;
  logic          first_reg, first_next;
  logic          level_reg, level_next;
  logic          press_reg, press_next;
  logic          release_reg, release_next;
  logic          repeat_reg, repeat_next;
  logic [CW-1:0] rep_last;

  // first_reg selects the long initial hold delay until the first auto-repeat fires
  assign rep_last = first_reg ? DELAY_LAST : RATE_LAST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      state_reg   <= RELEASED;
      stab_reg    <= '0;
      rep_reg     <= '0;
      first_reg   <= 1'b0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      repeat_reg  <= 1'b0;
    end else begin
      sync1_reg   <= raw;
      sync2_reg   <= sync1_reg;
      state_reg   <= state_next;
      stab_reg    <= stab_next;
      rep_reg     <= rep_next;
      first_reg   <= first_next;
      level_reg   <= level_next;
      press_reg   <= press_next;
      release_reg <= release_next;
      repeat_reg  <= repeat_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    stab_next    = (stab_reg == CNT_MAX) ? stab_reg : stab_reg + 1'b1;
    rep_next     = rep_reg;
    first_next   = first_reg;
    press_next   = 1'b0;
    release_next = 1'b0;
    repeat_next  = 1'b0;

    // Repeat timer keeps running through RELEASE_PEND so a bounce does not restart it
    if (state_reg == HELD || state_reg == RELEASE_PEND) begin
      if (rep_reg == rep_last) begin
        repeat_next = 1'b1;
        rep_next    = '0;
        first_next  = 1'b0;
      end else begin
        rep_next = rep_reg + 1'b1;
      end
    end

    case (state_reg)
      RELEASED: begin
        if (sync2_reg) begin
          state_next = PRESS_PEND;
          stab_next  = '0;
        end
      end
      PRESS_PEND: begin
        if (!sync2_reg) begin
          state_next = RELEASED;
        end else if (stab_reg >= STAB_LAST) begin
          state_next  = HELD;
          press_next  = 1'b1;
          repeat_next = 1'b1;
          rep_next    = '0;
          first_next  = 1'b1;
        end
      end
      HELD: begin
        if (!sync2_reg) begin
          state_next = RELEASE_PEND;
          stab_next  = '0;
        end
      end
      RELEASE_PEND: begin
        if (sync2_reg) begin
          state_next = HELD;
        end else if (stab_reg >= STAB_LAST) begin
          state_next   = RELEASED;
          release_next = 1'b1;
          repeat_next  = 1'b0;
        end
      end
      default: state_next = RELEASED;
    endcase

    level_next = (state_next == HELD) || (state_next == RELEASE_PEND);
  end

  assign level         = level_reg;
  assign press         = press_reg;
  assign release_pulse = release_reg;
  assign repeat_pulse  = repeat_reg;

endmodule

// File: rtl/button_debouncer.sv
// Five independent debounced push-buttons with press/release/auto-repeat pulses.
module button_debouncer
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = 1_000_000,
  parameter int REPEAT_DELAY_CYCLES = 50_000_000,
  parameter int REPEAT_RATE_CYCLES  = 10_000_000
) (
  input  logic                CLK100MHZ,
  input  logic                CPU_RESETN,
  input  logic                BTNC,
  input  logic                BTNU,
  input  logic                BTND,
  input  logic                BTNL,
  input  logic                BTNR,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_press,
  output logic [NUM_BTNS-1:0] btn_release,
  output logic [NUM_BTNS-1:0] btn_repeat
);

  logic [NUM_BTNS-1:0] raw;

  assign raw[BTN_C] = BTNC;
  assign raw[BTN_U] = BTNU;
  assign raw[BTN_D] = BTND;
  assign raw[BTN_L] = BTNL;
  assign raw[BTN_R] = BTNR;

  for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES)
    ) u_ch (
      .clk          (CLK100MHZ),
      .rst_n        (CPU_RESETN),
      .raw          (raw[gi]),
      .level        (btn_level[gi]),
      .press        (btn_press[gi]),
      .release_pulse(btn_release[gi]),
      .repeat_pulse (btn_repeat[gi])
    );
  end

endmodule
